rcu_nested_model: RTL and testbench

- Parametrised RCU model: NRDR reader processes and one updater share a flip bit and per-reader, per-phase counters.
- Read-side sections can nest up to NEST levels, so each counter is multi-bit rather than a toggle.
- A nondeterministic scheduler input advances exactly one process by one step per clock.
- Sits in the formal-benchmark tree as a model-checking target; `prop` is the grace-period safety invariant.

---
 rtl/rcu_nested_model.sv | 246 ++++++++++++++++++++++++
 tb/tb_rcu_nested_model.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rcu_nested_model.sv
// rcu_nested_model: RCU model with NRDR reader processes and one updater. They
// share a phase bit (flip) and a pair of per-reader, per-phase counters. A
// scheduler input (select) advances exactly one process by one step per clock.
// Read-side sections may nest, so each counter is multi-bit.
//
// Build option: define RCU_NEST_EN to enable nesting. Without it, nest_req is
// ignored, depth is fixed at 1 and the counters are 2 bits wide.
//
// Ports:
//   clock     rising-edge clock
//   reset_n   synchronous active-low reset
//   select    value < NRDR steps that reader; any other value steps the updater
//   nest_req  re-entry request, sampled only by a reader in R_CS2
//   prop      grace-period safety invariant: not (gp_done and any stale reader)
//   gp_done   one-cycle pulse after a grace period completes
//   gp_count  completed grace periods, mod 256
//   passctr   shared pass counter, mod 2^PCW
//   flip      current phase
//   upd_busy  updater is not in U_IDLE
//
// Handshake: there is none. Each clock, only the process chosen by select
// takes one step, and its effects are visible after that edge. Every process
// that is not selected holds all of its state.
module rcu_nested_model #(
    parameter int NRDR   = 4,
    parameter int SELW   = 3,
    parameter int PASSES = 10,
    parameter int PCW    = 8,
    parameter int NEST   = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [SELW-1:0] select,
    input  logic            nest_req,
    output logic            prop,
    output logic            gp_done,
    output logic [7:0]      gp_count,
    output logic [PCW-1:0]  passctr,
    output logic            flip,
    output logic            upd_busy
);
`ifdef RCU_NEST_EN
    localparam int CTRW = $clog2(NEST + 2);
`else
    localparam int CTRW = 2;
    localparam int unused_nest_p = NEST;
    logic unused_nest_req;
    assign unused_nest_req = nest_req;
`endif
    localparam int IDXW = (NRDR > 1) ? $clog2(NRDR) : 1;

    typedef enum logic [2:0] {
        R_IDLE, R_INC, R_CHK, R_CS1, R_CS2, R_DEC, R_DEC2
    } rd_state_t;

    typedef enum logic [3:0] {
        U_IDLE, U_INIT1, U_SCAN1, U_WAIT1, U_NEXT1,
        U_FLIP, U_INIT2, U_SCAN2, U_WAIT2, U_NEXT2
    } upd_state_t;

    rd_state_t       rd_state   [NRDR];
    rd_state_t       rd_state_n [NRDR];
    upd_state_t      upd_state, upd_state_n;
    logic [CTRW-1:0] ctr   [NRDR][2];
    logic [CTRW-1:0] ctr_n [NRDR][2];
`ifdef RCU_NEST_EN
    logic [CTRW-1:0] depth   [NRDR];
    logic [CTRW-1:0] depth_n [NRDR];
`endif
    logic [NRDR-1:0] lcl_flip, lcl_flip_n;
    logic [NRDR-1:0] both, both_n;
    logic [NRDR-1:0] stale, stale_n;
    logic [SELW-1:0] cpunum, cpunum_n;
    logic            flip_n;
    logic [PCW-1:0]  passctr_n;
    logic [7:0]      gp_count_n;
    logic            gp_done_n;
    logic [IDXW-1:0] rid, cid;
    logic            rd_sel, start_ok;

    assign rid      = select[IDXW-1:0];
    assign cid      = cpunum[IDXW-1:0];
    assign rd_sel   = (select < SELW'(NRDR));
    // Only new passes are gated. A section already in flight runs to completion.
    assign start_ok = (passctr < PCW'(PASSES));
    assign upd_busy = (upd_state != U_IDLE);
    assign prop     = ~(gp_done & (|stale));

    always_comb begin
        rd_state_n  = rd_state;
        upd_state_n = upd_state;
        ctr_n       = ctr;
`ifdef RCU_NEST_EN
        depth_n     = depth;
`endif
        lcl_flip_n  = lcl_flip;
        both_n      = both;
        stale_n     = stale;
        cpunum_n    = cpunum;
        flip_n      = flip;
        passctr_n   = passctr;
        gp_count_n  = gp_count;
        gp_done_n   = 1'b0;

        if (rd_sel) begin
            case (rd_state[rid])
                R_IDLE: if (start_ok) begin
                    lcl_flip_n[rid] = flip;
`ifdef RCU_NEST_EN
                    depth_n[rid]    = CTRW'(1);
`endif
                    rd_state_n[rid] = R_INC;
                end
                R_INC: begin
                    ctr_n[rid][lcl_flip[rid]] = ctr[rid][lcl_flip[rid]] + CTRW'(1);
                    rd_state_n[rid] = R_CHK;
                end
                R_CHK: begin
                    // If the phase moved since it was sampled, also hold the
                    // other phase's counter so that both updater scans see us.
                    if (flip == lcl_flip[rid]) begin
                        both_n[rid] = 1'b0;
                    end else begin
                        ctr_n[rid][~lcl_flip[rid]] = ctr[rid][~lcl_flip[rid]] + CTRW'(1);
                        both_n[rid] = 1'b1;
                    end
                    rd_state_n[rid] = R_CS1;
                end
                R_CS1: begin
                    passctr_n       = passctr + 1'b1;
                    rd_state_n[rid] = R_CS2;
                end
                R_CS2: begin
                    passctr_n       = passctr + 1'b1;
                    rd_state_n[rid] = R_DEC;
`ifdef RCU_NEST_EN
                    if (nest_req && (depth[rid] < CTRW'(NEST))) begin
                        depth_n[rid] = depth[rid] + CTRW'(1);
                        ctr_n[rid][lcl_flip[rid]] = ctr[rid][lcl_flip[rid]] + CTRW'(1);
                        rd_state_n[rid] = R_CS1;
                    end
`endif
                end
                R_DEC: begin
                    ctr_n[rid][lcl_flip[rid]] = ctr[rid][lcl_flip[rid]] - CTRW'(1);
`ifdef RCU_NEST_EN
                    depth_n[rid] = depth[rid] - CTRW'(1);
                    if (depth[rid] == CTRW'(1)) rd_state_n[rid] = R_DEC2;
`else
                    rd_state_n[rid] = R_DEC2;
`endif
                end
                R_DEC2: begin
                    if (both[rid]) begin
                        ctr_n[rid][~lcl_flip[rid]] = ctr[rid][~lcl_flip[rid]] - CTRW'(1);
                    end
                    stale_n[rid]    = 1'b0;
                    rd_state_n[rid] = R_IDLE;
                end
                default: rd_state_n[rid] = R_IDLE;
            endcase
        end else begin
            case (upd_state)
                U_IDLE: if (start_ok) begin
                    // Every reader that is already in a section must leave it
                    // before this grace period may complete.
                    for (int i = 0; i < NRDR; i++) begin
                        if (rd_state[i] != R_IDLE) stale_n[i] = 1'b1;
                    end
                    upd_state_n = U_INIT1;
                end
                U_INIT1: begin
                    cpunum_n    = '0;
                    upd_state_n = U_SCAN1;
                end
                U_SCAN1: upd_state_n = (cpunum < SELW'(NRDR)) ? U_WAIT1 : U_FLIP;
                U_WAIT1: if (ctr[cid][~flip] == '0) upd_state_n = U_NEXT1;
                U_NEXT1: begin
                    cpunum_n    = cpunum + 1'b1;
                    upd_state_n = U_SCAN1;
                end
                U_FLIP: begin
                    flip_n      = ~flip;
                    upd_state_n = U_INIT2;
                end
                U_INIT2: begin
                    cpunum_n    = '0;
                    upd_state_n = U_SCAN2;
                end
                U_SCAN2: begin
                    if (cpunum < SELW'(NRDR)) begin
                        upd_state_n = U_WAIT2;
                    end else begin
                        upd_state_n = U_IDLE;
                        gp_done_n   = 1'b1;
                        gp_count_n  = gp_count + 8'd1;
                    end
                end
                U_WAIT2: if (ctr[cid][~flip] == '0) upd_state_n = U_NEXT2;
                U_NEXT2: begin
                    cpunum_n    = cpunum + 1'b1;
                    upd_state_n = U_SCAN2;
                end
                default: upd_state_n = U_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NRDR; i++) begin
                rd_state[i] <= R_IDLE;
                ctr[i][0]   <= '0;
                ctr[i][1]   <= '0;
`ifdef RCU_NEST_EN
                depth[i]    <= '0;
`endif
            end
            upd_state <= U_IDLE;
            lcl_flip  <= '0;
            both      <= '0;
            stale     <= '0;
            cpunum    <= '0;
            flip      <= 1'b0;
            passctr   <= '0;
            gp_count  <= '0;
            gp_done   <= 1'b0;
        end else begin
            rd_state  <= rd_state_n;
            ctr       <= ctr_n;
`ifdef RCU_NEST_EN
            depth     <= depth_n;
`endif
            upd_state <= upd_state_n;
            lcl_flip  <= lcl_flip_n;
            both      <= both_n;
            stale     <= stale_n;
            cpunum    <= cpunum_n;
            flip      <= flip_n;
            passctr   <= passctr_n;
            gp_count  <= gp_count_n;
            gp_done   <= gp_done_n;
        end
    end

endmodule

// File: tb/tb_rcu_nested_model.sv
// tb_rcu_nested_model: directed scenarios plus randomized scheduling of
// rcu_nested_model (NRDR=2, PASSES=4). The DUT is compared every cycle against
// a step-level reference model of the readers and the updater.
module tb_rcu_nested_model;
    localparam int NRDR   = 2;
    localparam int SELW   = 2;
    localparam int PASSES = 4;
    localparam int PCW    = 8;
    localparam int NEST   = 2;
`ifdef RCU_NEST_EN
    localparam bit NEST_ON = 1'b1;
`else
    localparam bit NEST_ON = 1'b0;
`endif
    // Updater step index at which the final second-phase scan completes.
    localparam int K_DONE = 5 + 6 * NRDR;
    localparam int K_FLIP = 3 + 3 * NRDR;

    // ---------------- clock / reset / DUT ----------------
    logic            clock = 1'b0;
    logic            reset_n;
    logic [SELW-1:0] select;
    logic            nest_req;
    logic            prop, gp_done, flip, upd_busy;
    logic [7:0]      gp_count;
    logic [PCW-1:0]  passctr;

    always #5 clock = ~clock;

    rcu_nested_model #(
        .NRDR(NRDR), .SELW(SELW), .PASSES(PASSES), .PCW(PCW), .NEST(NEST)
    ) dut (
        .clock(clock), .reset_n(reset_n), .select(select), .nest_req(nest_req),
        .prop(prop), .gp_done(gp_done), .gp_count(gp_count), .passctr(passctr),
        .flip(flip), .upd_busy(upd_busy)
    );

    // ---------------- reference model ----------------
    // Reader pass position: 0 idle, 1 increment pending, 2 phase check pending,
    // 3 first section half, 4 second section half, 5 unwinding, 6 final release.
    int            rpos  [NRDR];
    bit            rl    [NRDR];
    int            rdep  [NRDR];
    bit            rb    [NRDR];
    int            mc    [NRDR][2];
    bit [NRDR-1:0] ms;
    int            uk;
    bit            mf;
    int            mp;
    int            mg;
    bit            mgd;

    logic [7:0]    exp_q[$];
    int            n_checks = 0;
    int            n_errors = 0;
    bit            chk_en = 1'b0;

    function automatic void m_reset();
        for (int r = 0; r < NRDR; r++) begin
            rpos[r] = 0; rl[r] = 0; rdep[r] = 0; rb[r] = 0;
            mc[r][0] = 0; mc[r][1] = 0;
        end
        ms = '0; uk = 0; mf = 0; mp = 0; mg = 0; mgd = 0;
        exp_q.delete();
    endfunction

    function automatic void m_step(input int sel, input bit nreq);
        int r, base;
        mgd = 0;
        if (sel < NRDR) begin
            r = sel;
            case (rpos[r])
                0: if (mp < PASSES) begin rl[r] = mf; rdep[r] = 1; rpos[r] = 1; end
                1: begin mc[r][rl[r]]++; rpos[r] = 2; end
                2: begin
                    if (mf == rl[r]) rb[r] = 0;
                    else begin mc[r][!rl[r]]++; rb[r] = 1; end
                    rpos[r] = 3;
                end
                3: begin mp = (mp + 1) & 255; rpos[r] = 4; end
                4: begin
                    mp = (mp + 1) & 255;
                    if (NEST_ON && nreq && rdep[r] < NEST) begin
                        rdep[r]++; mc[r][rl[r]]++; rpos[r] = 3;
                    end else rpos[r] = 5;
                end
                5: begin
                    mc[r][rl[r]]--; rdep[r]--;
                    if (rdep[r] == 0) rpos[r] = 6;
                end
                default: begin
                    if (rb[r]) mc[r][!rl[r]]--;
                    ms[r] = 0; rpos[r] = 0;
                end
            endcase
        end else begin
            // Updater position uk: 0 idle, 1 init, then per reader j a triple
            // (scan, wait, next) from base, final scan, flip, init, second set.
            if (uk == 0) begin
                if (mp < PASSES) begin
                    for (int i = 0; i < NRDR; i++) if (rpos[i] != 0) ms[i] = 1;
                    uk = 1;
                end
            end else if (uk == K_FLIP) begin
                mf = !mf; uk++;
            end else if (uk == K_DONE) begin
                uk = 0; mgd = 1; mg = (mg + 1) & 255;
                exp_q.push_back(8'(mg));
            end else begin
                base = (uk < K_FLIP) ? 2 : K_FLIP + 2;
                if (uk >= base && (uk - base) % 3 == 1) begin
                    if (mc[(uk - base) / 3][!mf] == 0) uk++;
                end else uk++;
            end
        end
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check("flip", 32'(flip), 32'(mf));
            check("passctr", 32'(passctr), 32'(mp));
            check("gp_count", 32'(gp_count), 32'(mg));
            check("gp_done", 32'(gp_done), 32'(mgd));
            check("upd_busy", 32'(upd_busy), 32'(uk != 0));
            check("prop", 32'(prop), 32'(!(mgd && (ms != 0))));
            for (int r = 0; r < NRDR; r++) begin
                check("ctr_p0", 32'(dut.ctr[r][0]), 32'(mc[r][0]));
                check("ctr_p1", 32'(dut.ctr[r][1]), 32'(mc[r][1]));
            end
            if (gp_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL gp_pulse: got a pulse, expected none (t=%0t)", $time);
                end else begin
                    check("gp_pulse_count", 32'(gp_count), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic cycle(input int s, input bit n, input bit rst);
        select   = SELW'(s);
        nest_req = n;
        reset_n  = ~rst;
        if (rst) m_reset(); else m_step(s, n);
        @(negedge clock);
        #1;
    endtask

    task automatic steps(input int s, input bit n, input int count);
        for (int i = 0; i < count; i++) cycle(s, n, 1'b0);
    endtask

    int peak;
    bit rnd_rst;

    initial begin
        reset_n = 1'b0; select = '0; nest_req = 1'b0;
        m_reset();
        repeat (2) @(negedge clock);
        #1;
        chk_en = 1'b1;
        check("rst_prop", 32'(prop), 32'd1);
        check("rst_passctr", 32'(passctr), 32'd0);
        check("rst_upd_busy", 32'(upd_busy), 32'd0);

        // Grace period with all readers idle: 6*NRDR+6 = 18 updater steps.
        steps(NRDR, 1'b0, 17);
        check("t1_gp_early", 32'(gp_done), 32'd0);
        steps(NRDR, 1'b0, 1);
        check("t1_gp_done", 32'(gp_done), 32'd1);
        check("t1_gp_count", 32'(gp_count), 32'd1);
        check("t1_flip", 32'(flip), 32'd1);
        check("t1_prop", 32'(prop), 32'd1);
        steps(0, 1'b0, 1);
        check("t1_gp_pulse_end", 32'(gp_done), 32'd0);

        // Reader 0 in its section blocks the second-phase wait.
        cycle(0, 1'b0, 1'b1);
        steps(0, 1'b0, 3);
        steps(NRDR, 1'b0, 20);
        check("t2_stall_gp", 32'(gp_done), 32'd0);
        check("t2_stall_busy", 32'(upd_busy), 32'd1);
        check("t2_stall_flip", 32'(flip), 32'd1);
        steps(0, 1'b0, 4);
        steps(NRDR, 1'b0, 6);
        check("t2_gp_done", 32'(gp_done), 32'd1);
        check("t2_prop", 32'(prop), 32'd1);
        check("t2_gp_count", 32'(gp_count), 32'd1);

        // Phase flip between reader 1 sampling flip and its check.
        cycle(0, 1'b0, 1'b1);
        steps(1, 1'b0, 1);
        steps(NRDR, 1'b0, 10);
        check("t3_flip", 32'(flip), 32'd1);
        steps(1, 1'b0, 2);
        check("t3_both", 32'(dut.both[1]), 32'd1);
        check("t3_ctr10", 32'(dut.ctr[1][0]), 32'd1);
        check("t3_ctr11", 32'(dut.ctr[1][1]), 32'd1);
        steps(1, 1'b0, 4);
        check("t3_ctr10_done", 32'(dut.ctr[1][0]), 32'd0);
        check("t3_ctr11_done", 32'(dut.ctr[1][1]), 32'd0);

        // Nested section on reader 0 with nest_req held high.
        cycle(0, 1'b0, 1'b1);
        peak = 0;
        for (int i = 0; i < (NEST_ON ? 10 : 7); i++) begin
            steps(0, 1'b1, 1);
            if (int'(dut.ctr[0][0]) > peak) peak = int'(dut.ctr[0][0]);
        end
        check("t4_peak", 32'(peak), NEST_ON ? 32'd2 : 32'd1);
        check("t4_passctr", 32'(passctr), NEST_ON ? 32'd4 : 32'd2);
        check("t4_ctr_clear", 32'(dut.ctr[0][0]), 32'd0);

        // PASSES boundary: only new starts are gated.
        cycle(0, 1'b0, 1'b1);
        steps(0, 1'b0, 7);
        steps(1, 1'b0, 3);
        steps(0, 1'b0, 7);
        check("t5_passctr4", 32'(passctr), 32'd4);
        steps(NRDR, 1'b0, 3);
        check("t5_upd_idle", 32'(upd_busy), 32'd0);
        steps(0, 1'b0, 2);
        check("t5_passctr_hold", 32'(passctr), 32'd4);
        steps(1, 1'b0, 4);
        check("t5_passctr6", 32'(passctr), 32'd6);
        steps(1, 1'b0, 1);
        check("t5_passctr6_hold", 32'(passctr), 32'd6);

        // Reset while the updater waits and reader 0 unwinds.
        cycle(0, 1'b0, 1'b1);
        steps(NRDR, 1'b0, 18);
        steps(0, 1'b0, 5);
        steps(NRDR, 1'b0, 3);
        check("t6_busy_before", 32'(upd_busy), 32'd1);
        cycle(0, 1'b0, 1'b1);
        check("t6_prop", 32'(prop), 32'd1);
        check("t6_gp_count", 32'(gp_count), 32'd0);
        check("t6_flip", 32'(flip), 32'd0);
        check("t6_passctr", 32'(passctr), 32'd0);
        check("t6_busy", 32'(upd_busy), 32'd0);
        check("t6_ctr01", 32'(dut.ctr[0][1]), 32'd0);

        // Randomized scheduling with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            rnd_rst = ($urandom_range(0, 59) == 0);
            cycle(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rnd_rst);
        end
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
